// File: rtl/ram_weight_burst.sv
// ram_weight_burst
//  Weight store for a three-layer network (hidden1, hidden2, output), held in
//  one flat block RAM. Serves single-word reads and writes, and an autonomous
//  burst read that streams consecutive weights of one layer, one per cycle.
//  Every request is range checked against the depth of its layer.
// Ports
//  clk, rst                            clock, async active-high reset
//  i_ram_enable/i_rw_select            single access strobe, 1=read 0=write
//  i_weight_layer/i_weight_addr/i_weight  single access layer, address, data
//  i_burst_start/_layer/_addr/_len     burst request
//  o_busy                              burst in progress
//  o_weight_valid/_layer/_addr, o_weight  read data stream (held when idle)
//  o_burst_done                        pulses with the last burst word
//  o_addr_error                        pulses one cycle after a rejected request
module ram_weight_burst #(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int ADDR_WIDTH                    = 11,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_ram_enable,
  input  logic                   i_rw_select,
  input  logic [LAYER_WIDTH-1:0] i_weight_layer,
  input  logic [ADDR_WIDTH-1:0]  i_weight_addr,
  input  logic [DATA_WIDTH-1:0]  i_weight,
  input  logic                   i_burst_start,
  input  logic [LAYER_WIDTH-1:0] i_burst_layer,
  input  logic [ADDR_WIDTH-1:0]  i_burst_addr,
  input  logic [ADDR_WIDTH-1:0]  i_burst_len,
  output logic                   o_busy,
  output logic                   o_weight_valid,
  output logic [LAYER_WIDTH-1:0] o_weight_layer,
  output logic [ADDR_WIDTH-1:0]  o_weight_addr,
  output logic [DATA_WIDTH-1:0]  o_weight,
  output logic                   o_burst_done,
  output logic                   o_addr_error
);
  localparam int D1    = NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1);
  localparam int D2    = NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1);
  localparam int D3    = NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1);
  localparam int TOTAL = D1 + D2 + D3;
  localparam int MW    = $clog2(TOTAL);

  typedef enum logic {IDLE, BURST} state_t;

  // Depth and flat-RAM base of each layer; layer 0 has depth 0.
  function automatic logic [ADDR_WIDTH:0] depth_of(input logic [LAYER_WIDTH-1:0] l);
    case (l)
      LAYER_WIDTH'(1): return (ADDR_WIDTH+1)'(D1);
      LAYER_WIDTH'(2): return (ADDR_WIDTH+1)'(D2);
      LAYER_WIDTH'(3): return (ADDR_WIDTH+1)'(D3);
      default:         return '0;
    endcase
  endfunction

  function automatic logic [ADDR_WIDTH:0] base_of(input logic [LAYER_WIDTH-1:0] l);
    case (l)
      LAYER_WIDTH'(2): return (ADDR_WIDTH+1)'(D1);
      LAYER_WIDTH'(3): return (ADDR_WIDTH+1)'(D1 + D2);
      default:         return '0;
    endcase
  endfunction

  state_t                 state, state_nx;
  logic [LAYER_WIDTH-1:0] b_layer;
  logic [ADDR_WIDTH-1:0]  b_addr, b_left;
  logic                   rd_en, wr_en, err, zero_done, load, last;
  logic [LAYER_WIDTH-1:0] acc_layer;
  logic [ADDR_WIDTH-1:0]  acc_addr;
  logic [MW-1:0]          flat;
  logic                   single_ok, burst_ok;
  logic [ADDR_WIDTH:0]    burst_end;
  logic [DATA_WIDTH-1:0]  mem [TOTAL];
  logic [DATA_WIDTH-1:0]  rd_q;
  logic                   rd_seen;

  // One extra bit so addr+len cannot wrap past the layer depth.
  assign burst_end = {1'b0, i_burst_addr} + {1'b0, i_burst_len};
  assign single_ok = (i_weight_layer != '0) && ({1'b0, i_weight_addr} < depth_of(i_weight_layer));
  assign burst_ok  = (i_burst_layer != '0) && (burst_end <= depth_of(i_burst_layer));

  always_comb begin
    state_nx  = state;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    err       = 1'b0;
    zero_done = 1'b0;
    load      = 1'b0;
    last      = 1'b0;
    acc_layer = i_weight_layer;
    acc_addr  = i_weight_addr;
    unique case (state)
      IDLE: begin
        // Burst wins over a same-cycle single access; the single one is dropped.
        if (i_burst_start) begin
          if (!burst_ok)              err       = 1'b1;
          else if (i_burst_len == '0) zero_done = 1'b1;
          else begin
            load     = 1'b1;
            state_nx = BURST;
          end
        end else if (i_ram_enable) begin
          if (!single_ok)       err   = 1'b1;
          else if (i_rw_select) rd_en = 1'b1;
          else                  wr_en = 1'b1;
        end
      end
      BURST: begin
        rd_en     = 1'b1;
        acc_layer = b_layer;
        acc_addr  = b_addr;
        last      = (b_left == ADDR_WIDTH'(1));
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign flat = MW'(base_of(acc_layer) + {1'b0, acc_addr});

  // RAM and its read register carry no reset so they map onto block RAM.
  // Read-first: a read and a write in the same cycle see the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[flat] <= i_weight;
    if (rd_en) rd_q      <= mem[flat];
  end

  // Read data shows 0 until the first read after reset, then holds.
  assign o_weight = rd_seen ? rd_q : '0;
  assign o_busy   = (state == BURST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      b_layer        <= '0;
      b_addr         <= '0;
      b_left         <= '0;
      rd_seen        <= 1'b0;
      o_weight_valid <= 1'b0;
      o_weight_layer <= '0;
      o_weight_addr  <= '0;
      o_burst_done   <= 1'b0;
      o_addr_error   <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        b_layer <= i_burst_layer;
        b_addr  <= i_burst_addr;
        b_left  <= i_burst_len;
      end else if (state == BURST) begin
        b_addr <= b_addr + ADDR_WIDTH'(1);
        b_left <= b_left - ADDR_WIDTH'(1);
      end
      if (rd_en) begin
        rd_seen        <= 1'b1;
        o_weight_layer <= acc_layer;
        o_weight_addr  <= acc_addr;
      end
      o_weight_valid <= rd_en;
      o_burst_done   <= zero_done | last;
      o_addr_error   <= err;
    end
  end
endmodule
